// File: rtl/packet_rx.sv
// packet_rx
// Receives a PKT_LEN-bit packet sent as consecutive 8N1 UART byte frames and
// presents it on a parallel bus.
//
// Parameters
//   CLK_PER_SAMP  : clocks per oversample tick
//   SAMP_PER_BIT  : oversample ticks per bit period (even, >= 4)
//   PKT_LEN       : packet width in bits (multiple of 8)
//   WAITING_COUNT : idle clocks mid-packet before a partial packet is dropped
//
// Ports
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset
//   rx        : asynchronous serial input, idle high
//   ready     : one-cycle pulse, data_out holds a newly completed packet
//   data_out  : last complete packet, first received byte in [7:0]
//   frame_err : one-cycle pulse on a bad stop bit
//   busy      : high while a packet is partially received
module packet_rx #(
    parameter int CLK_PER_SAMP  = 423,
    parameter int SAMP_PER_BIT  = 16,
    parameter int PKT_LEN       = 208,
    parameter int WAITING_COUNT = 130_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err,
    output logic               busy
);

    localparam int NBYTES = PKT_LEN / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int SC_W   = $clog2(CLK_PER_SAMP + 1);
    localparam int TC_W   = $clog2(SAMP_PER_BIT + 1);
    localparam int TO_W   = $clog2(WAITING_COUNT + 1);

    localparam logic [SC_W-1:0]  SAMP_LAST = SC_W'(CLK_PER_SAMP - 1);
    localparam logic [TC_W-1:0]  HALF_LAST = TC_W'(SAMP_PER_BIT / 2 - 1);
    localparam logic [TC_W-1:0]  BIT_LAST  = TC_W'(SAMP_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(WAITING_COUNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic               rx_p0;
    logic               rx_s;
    logic [SC_W-1:0]    samp_cnt;
    logic               tick;
    logic [TC_W-1:0]    tick_cnt;
    logic [2:0]         bit_idx;
    logic [IDX_W-1:0]   byte_idx;
    logic [TO_W-1:0]    to_cnt;
    logic               wait_high;
    logic               start_det;
    logic [7:0]         shift;
    logic [PKT_LEN-1:0] pkt;
    logic [PKT_LEN-1:0] pkt_next;

    // Two-flop synchroniser; reset to the idle level so no false start follows reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // After a frame error the line may still be low; wait_high blocks a false start.
    assign start_det = (state == IDLE) && !wait_high && !rx_s;

    // Free-running tick divider, re-phased on each start edge so sample
    // points are measured from detection.
    assign tick = (samp_cnt == SAMP_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in || start_det || tick) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

    // Packet with the byte just received dropped into its slot.
    always_comb begin
        pkt_next = pkt;
        for (int i = 0; i < NBYTES; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                pkt_next[i*8 +: 8] = shift;
            end
        end
    end

    assign busy = (byte_idx != '0) || (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            to_cnt    <= '0;
            wait_high <= 1'b0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            data_out  <= '0;
        end else begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (wait_high && rx_s) begin
                        wait_high <= 1'b0;
                    end
                    if (byte_idx != '0) begin
                        if (to_cnt == TO_LAST) begin
                            byte_idx <= '0;
                            to_cnt   <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    // A start edge coinciding with the timeout still clears
                    // byte_idx above, so the new byte becomes byte 0.
                    if (start_det) begin
                        state    <= START;
                        tick_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shift    <= {rx_s, shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_s) begin
                                pkt <= pkt_next;
                                if (byte_idx == IDX_LAST) begin
                                    data_out <= pkt_next;
                                    ready    <= 1'b1;
                                    byte_idx <= '0;
                                end else begin
                                    byte_idx <= byte_idx + 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                byte_idx  <= '0;
                                wait_high <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_rx.sv
module tb_packet_rx;

    localparam int CPS     = 4;
    localparam int SPB     = 4;
    localparam int PLEN    = 16;
    localparam int WAITC   = 200;
    localparam int BIT_CLK = CPS * SPB;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rx;
    logic            ready;
    logic [PLEN-1:0] data_out;
    logic            frame_err;
    logic            busy;

    always #5 clk_in = ~clk_in;

    packet_rx #(
        .CLK_PER_SAMP (CPS),
        .SAMP_PER_BIT (SPB),
        .PKT_LEN      (PLEN),
        .WAITING_COUNT(WAITC)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx       (rx),
        .ready    (ready),
        .data_out (data_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_ready = 0;
    int n_ferr  = 0;
    logic [PLEN-1:0] exp_q[$];
    logic prev_ready = 1'b0;
    logic prev_ferr  = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every ready pulse consumes one expected packet.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_ready = 1'b0;
            prev_ferr  = 1'b0;
        end else begin
            if (ready) begin
                n_ready++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: data_out 0x%0h, no packet expected", data_out);
                end else begin
                    check("scoreboard_packet", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) n_ferr++;
            if (ready && frame_err) begin
                n_bad++;
                $display("FAIL strobe_overlap: ready=1 frame_err=1, required never both");
            end
            if ((ready && prev_ready) || (frame_err && prev_ferr)) begin
                n_bad++;
                $display("FAIL pulse_width: strobe high 2 cycles, required 1");
            end
            prev_ready = ready;
            prev_ferr  = frame_err;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] exp);
        exp_q.push_back(exp);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int r0;
        int f0;
        logic [7:0] partial;

        vecs[0] = '{"a5_3c", 8'hA5, 8'h3C, 16'h3CA5};
        vecs[1] = '{"81_7e", 8'h81, 8'h7E, 16'h7E81};
        vecs[2] = '{"c3_5a", 8'hC3, 8'h5A, 16'h5AC3};
        vecs[3] = '{"01_80", 8'h01, 8'h80, 16'h8001};

        rx     = 1'b1;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("reset_ready", 32'(ready), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_data_out", 32'(data_out), 0);
        rst_in = 1'b0;
        idle(10);

        // Table-driven packets, bytes back-to-back within each packet.
        for (int i = 0; i < 4; i++) begin
            r0 = n_ready;
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].exp);
            idle(20);
            check({vecs[i].name, "_ready_count"}, 32'(n_ready - r0), 1);
            check({vecs[i].name, "_data_out"}, 32'(data_out), 32'(vecs[i].exp));
            check({vecs[i].name, "_busy"}, 32'(busy), 0);
        end

        // Bad stop bit, then a good packet.
        r0 = n_ready;
        f0 = n_ferr;
        send_byte(8'h12, 1'b0);
        idle(20);
        check("ferr_count", 32'(n_ferr - f0), 1);
        check("ferr_no_ready", 32'(n_ready - r0), 0);
        check("ferr_busy", 32'(busy), 0);
        send_pkt(8'h01, 8'h02, 16'h0201);
        idle(20);
        check("after_ferr_data_out", 32'(data_out), 32'h0201);
        check("after_ferr_ready_count", 32'(n_ready - r0), 1);

        // Start glitch of 4 clocks.
        r0 = n_ready;
        f0 = n_ferr;
        rx = 1'b0;
        repeat (4) @(negedge clk_in);
        check("glitch_busy_high", 32'(busy), 1);
        idle(20);
        check("glitch_busy_low", 32'(busy), 0);
        check("glitch_no_ready", 32'(n_ready - r0), 0);
        check("glitch_no_ferr", 32'(n_ferr - f0), 0);

        // Idle timeout drops a lone first byte.
        r0 = n_ready;
        send_byte(8'h55, 1'b1);
        idle(150);
        check("timeout_busy_before", 32'(busy), 1);
        idle(100);
        check("timeout_busy_after", 32'(busy), 0);
        check("timeout_no_ready", 32'(n_ready - r0), 0);
        send_pkt(8'hAA, 8'hBB, 16'hBBAA);
        idle(20);
        check("timeout_data_out", 32'(data_out), 32'hBBAA);
        check("timeout_ready_count", 32'(n_ready - r0), 1);

        // Reset in the middle of bit 4 of the first byte.
        partial = 8'h33;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        rx = partial[4];
        repeat (BIT_CLK / 2) @(negedge clk_in);
        check("midreset_busy_before", 32'(busy), 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        rx     = 1'b1;
        check("midreset_ready", 32'(ready), 0);
        check("midreset_frame_err", 32'(frame_err), 0);
        check("midreset_busy", 32'(busy), 0);
        check("midreset_data_out", 32'(data_out), 0);
        idle(20);
        r0 = n_ready;
        send_pkt(8'h11, 8'h22, 16'h2211);
        idle(20);
        check("after_reset_data_out", 32'(data_out), 32'h2211);
        check("after_reset_ready_count", 32'(n_ready - r0), 1);

        // Two packets; data_out holds between commits.
        r0 = n_ready;
        send_pkt(8'h00, 8'hFF, 16'hFF00);
        idle(30);
        check("hold_first", 32'(data_out), 32'hFF00);
        check("hold_busy", 32'(busy), 0);
        send_pkt(8'hFF, 8'h00, 16'h00FF);
        idle(20);
        check("hold_second", 32'(data_out), 32'h00FF);
        check("hold_ready_count", 32'(n_ready - r0), 2);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_in);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
